// File: rtl/risc_fetch_ctrl_32.sv
// Instruction fetch sequencer: owns the PC, fetches from a combinational
// instruction memory into a small FIFO and hands words to decode via valid/ready.
module risc_fetch_ctrl_32 #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          MEM_DEPTH  = 64,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] HALT_WORD  = 32'h0010_0073,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetchEn,
  output logic [31:0] instrAddr_32,
  input  logic [31:0] readData_32,
  output logic        instrValid,
  input  logic        instrReady,
  output logic [31:0] instrOut_32,
  output logic [31:0] instrPc_32,
  input  logic        redirectEn,
  input  logic [31:0] redirectPc_32,
  input  logic        resume,
  output logic        halted,
  output logic        misalignErr,
  output logic        rangeErr
);

  localparam int                PTR_W     = $clog2(FIFO_DEPTH);
  localparam int                CNT_W     = PTR_W + 1;
  localparam logic [31:0]       MEM_BYTES = 32'(MEM_DEPTH * 4);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_fifo_pc   [FIFO_DEPTH];
  logic [31:0]      r_fifo_word [FIFO_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_hold_pc;
  logic [31:0]      r_hold_word;
  logic             r_misalign;
  logic             r_range;

  logic             w_valid;
  logic             w_pop;
  logic             w_in_range;
  logic [31:0]      w_word;
  logic             w_fetch;
  logic [31:0]      w_head_pc;
  logic [31:0]      w_head_word;

  assign w_valid     = (r_count != '0);
  assign w_pop       = w_valid && instrReady;
  assign w_in_range  = (r_pc < MEM_BYTES);
  assign w_word      = w_in_range ? readData_32 : NOP_WORD;
  // A full FIFO may still accept a fetch when the head leaves in the same cycle.
  assign w_fetch     = (r_state == S_RUN) && fetchEn && !redirectEn &&
                       ((r_count != CNT_FULL) || w_pop);
  assign w_head_pc   = r_fifo_pc[r_rd_ptr];
  assign w_head_word = r_fifo_word[r_rd_ptr];

  assign instrAddr_32 = r_pc;
  assign instrValid   = w_valid;
  assign instrPc_32   = w_valid ? w_head_pc   : r_hold_pc;
  assign instrOut_32  = w_valid ? w_head_word : r_hold_word;
  assign halted       = (r_state == S_HALT);
  assign misalignErr  = r_misalign;
  assign rangeErr     = r_range;

  // Storage needs no reset: the head is only shown while count is non-zero.
  always_ff @(posedge clk) begin
    if (w_fetch) begin
      r_fifo_pc[r_wr_ptr]   <= r_pc;
      r_fifo_word[r_wr_ptr] <= w_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirectEn) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_fetch) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_fetch && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_fetch && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  // Last shown head, so the outputs hold their value once the FIFO drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_pc   <= '0;
      r_hold_word <= '0;
    end else if (w_valid) begin
      r_hold_pc   <= w_head_pc;
      r_hold_word <= w_head_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
      r_range    <= 1'b0;
    end else begin
      r_misalign <= redirectEn && (redirectPc_32[1:0] != 2'b00);
      if (redirectEn) begin
        r_pc    <= {redirectPc_32[31:2], 2'b00};
        r_range <= 1'b0;
        if (r_state == S_HALT) r_state <= S_RUN;
      end else begin
        if (w_fetch) begin
          r_pc <= r_pc + 32'd4;
          if (!w_in_range) r_range <= 1'b1;
        end
        case (r_state)
          S_IDLE:  if (fetchEn) r_state <= S_RUN;
          S_RUN:   if (w_fetch && (w_word == HALT_WORD)) r_state <= S_HALT;
          S_HALT:  if (resume) r_state <= S_RUN;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_risc_fetch_ctrl_32.sv
// Bench for risc_fetch_ctrl_32: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_risc_fetch_ctrl_32;

  localparam logic [31:0] HALT_W = 32'h0010_0073;
  localparam logic [31:0] NOP_W  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetchEn = 1'b0;
  logic [31:0] instrAddr_32;
  logic [31:0] readData_32;
  logic        instrValid;
  logic        instrReady = 1'b0;
  logic [31:0] instrOut_32;
  logic [31:0] instrPc_32;
  logic        redirectEn = 1'b0;
  logic [31:0] redirectPc_32 = '0;
  logic        resume = 1'b0;
  logic        halted;
  logic        misalignErr;
  logic        rangeErr;

  logic [31:0] mem [64];

  assign readData_32 = (instrAddr_32 < 32'd256) ? mem[instrAddr_32[7:2]] : 32'hBAD0_BAD0;

  always #5 clk = ~clk;

  risc_fetch_ctrl_32 dut (
    .clk(clk), .rst_n(rst_n), .fetchEn(fetchEn),
    .instrAddr_32(instrAddr_32), .readData_32(readData_32),
    .instrValid(instrValid), .instrReady(instrReady),
    .instrOut_32(instrOut_32), .instrPc_32(instrPc_32),
    .redirectEn(redirectEn), .redirectPc_32(redirectPc_32),
    .resume(resume), .halted(halted),
    .misalignErr(misalignErr), .rangeErr(rangeErr)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of {pc, word}, a PC and a mode (0 idle, 1 run, 2 halt).
  typedef struct packed { logic [31:0] pc; logic [31:0] w; } ent_t;
  ent_t        m_q[$];
  int          m_st;
  logic [31:0] m_pc;
  bit          m_rng, m_mis;
  ent_t        m_last;

  task automatic m_reset();
    m_q.delete();
    m_st   = 0;
    m_pc   = 32'h0;
    m_rng  = 1'b0;
    m_mis  = 1'b0;
    m_last = '0;
  endtask

  task automatic m_step(input bit fe, input bit rdy, input bit rde,
                        input logic [31:0] rpc, input bit res);
    bit          pop, fetch;
    logic [31:0] w;
    ent_t        e;
    pop = (m_q.size() != 0) && rdy;
    if (rde) begin
      m_q.delete();
      m_pc  = {rpc[31:2], 2'b00};
      m_rng = 1'b0;
      m_mis = (rpc[1:0] != 2'b00);
      if (m_st == 2) m_st = 1;
    end else begin
      m_mis = 1'b0;
      fetch = (m_st == 1) && fe && ((m_q.size() < 2) || pop);
      if (pop) void'(m_q.pop_front());
      if (fetch) begin
        if (m_pc < 32'd256) w = mem[m_pc[7:2]];
        else begin
          w     = NOP_W;
          m_rng = 1'b1;
        end
        e.pc = m_pc;
        e.w  = w;
        m_q.push_back(e);
        m_pc = m_pc + 32'd4;
        if (w == HALT_W) m_st = 2;
      end else if (m_st == 0 && fe) m_st = 1;
      else if (m_st == 2 && res) m_st = 1;
    end
  endtask

  task automatic check_all();
    chk("addr", instrAddr_32, m_pc);
    chk("valid", 32'(instrValid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) m_last = m_q[0];
    chk("head_pc", instrPc_32, m_last.pc);
    chk("head_word", instrOut_32, m_last.w);
    chk("halted", 32'(halted), 32'(m_st == 2));
    chk("misalign", 32'(misalignErr), 32'(m_mis));
    chk("range", 32'(rangeErr), 32'(m_rng));
  endtask

  task automatic cyc(input bit fe, input bit rdy, input bit rde,
                     input logic [31:0] rpc, input bit res);
    @(negedge clk);
    check_all();
    fetchEn       = fe;
    instrReady    = rdy;
    redirectEn    = rde;
    redirectPc_32 = rpc;
    resume        = res;
    m_step(fe, rdy, rde, rpc, res);
    @(posedge clk);
  endtask

  task automatic idle_inputs();
    fetchEn = 1'b0; instrReady = 1'b0; redirectEn = 1'b0;
    redirectPc_32 = '0; resume = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    m_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic mid_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(instrValid), 32'd0);
    chk("async_rst_addr", instrAddr_32, 32'h0);
    idle_inputs();
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill_seq();
    for (int i = 0; i < 64; i++) mem[i] = 32'h100 + 32'(i);
  endtask

  initial begin
    logic [31:0] rpc;
    fill_seq();
    m_reset();
    #1;
    check_all();
    do_reset();

    // streaming
    repeat (8) cyc(1, 1, 0, 0, 0);
    // backpressure then release
    do_reset();
    repeat (6) cyc(1, 0, 0, 0, 0);
    repeat (6) cyc(1, 1, 0, 0, 0);
    // misaligned redirect with full FIFO and a pop pending
    repeat (3) cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 32'h0000_0022, 0);
    repeat (4) cyc(1, 1, 0, 0, 0);
    // halt on EBREAK at word 3, drain, resume
    mem[3] = HALT_W;
    do_reset();
    repeat (10) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 1);
    repeat (4) cyc(1, 1, 0, 0, 0);
    mem[3] = 32'h103;
    // end of memory, out of range, cleared by redirect
    cyc(1, 1, 1, 32'h0000_00FC, 0);
    repeat (4) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 32'h0000_0000, 0);
    repeat (3) cyc(1, 1, 0, 0, 0);
    // PC wrap at top of address space
    cyc(1, 1, 1, 32'hFFFF_FFF8, 0);
    repeat (5) cyc(1, 1, 0, 0, 0);
    // pause in RUN
    repeat (3) cyc(0, 1, 0, 0, 0);
    repeat (2) cyc(1, 1, 0, 0, 0);
    // async reset with entries buffered
    repeat (3) cyc(1, 0, 0, 0, 0);
    mid_reset();
    // redirect while IDLE only loads the PC
    cyc(0, 1, 1, 32'h0000_0041, 0);
    repeat (4) cyc(1, 1, 0, 0, 0);

    // random traffic over random memory with sprinkled EBREAKs
    for (int i = 0; i < 64; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? HALT_W : $urandom;
    do_reset();
    for (int n = 0; n < 900; n++) begin
      if (n % 300 == 299) mid_reset();
      if ($urandom_range(0, 3) == 0) rpc = $urandom;
      else rpc = 32'($urandom_range(0, 280));
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 15) == 0, rpc, $urandom_range(0, 5) == 0);
    end
    @(negedge clk);
    check_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
